// File: rtl/approx_mult_2step_pipe.sv
// Two-stage unsigned multiplier with optional low-column truncation.
// Stage 1 compresses partial products into two carry-save rows; stage 2 runs the final adder.
module approx_mult_2step_pipe #(
   parameter int WIDTH      = 8,
   parameter int TRUNC_COLS = WIDTH / 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   x,
   input  logic [WIDTH-1:0]   y,
   input  logic               mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH:0]   prod,
   output logic               out_mode
);

   localparam int RW = 2 * WIDTH - 1;

   logic [RW-1:0]    w_sum_row;
   logic [RW-1:0]    w_carry_row;
   logic [2*WIDTH:0] w_final;
   logic             w_stall;

   logic [RW-1:0]    r_row_a;
   logic [RW-1:0]    r_row_b;
   logic             r_mode1;
   logic             r_v1;
   logic             r_v2;
   logic [2*WIDTH:0] r_prod;
   logic             r_out_mode;

   assign w_stall  = r_v2 & ~out_ready;
   assign in_ready = ~(w_stall & r_v1);

   // Linear 3:2 carry-save array: after row i both vectors stay below 2^(WIDTH+i),
   // so the carry shifted out of the top bit is always zero and the rows stay exact.
   always_comb begin : csa_array
      logic [RW-1:0] pp_row;
      logic [RW-1:0] acc_s;
      logic [RW-1:0] acc_c;
      logic [RW-1:0] nxt_c;
      acc_s  = '0;
      acc_c  = '0;
      pp_row = '0;
      nxt_c  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pp_row = '0;
         for (int j = 0; j < WIDTH; j++) begin
            if ((mode == 1'b0) || ((i + j) >= TRUNC_COLS)) begin
               pp_row[i+j] = x[j] & y[i];
            end else begin
               pp_row[i+j] = 1'b0;
            end
         end
         nxt_c = ((acc_s & acc_c) | (acc_s & pp_row) | (acc_c & pp_row)) << 1;
         acc_s = acc_s ^ acc_c ^ pp_row;
         acc_c = nxt_c;
      end
      w_sum_row   = acc_s;
      w_carry_row = acc_c;
   end

   assign w_final = {2'b00, r_row_a} + {2'b00, r_row_b};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v1    <= 1'b0;
         r_row_a <= '0;
         r_row_b <= '0;
         r_mode1 <= 1'b0;
      end else if (in_ready) begin
         r_v1 <= in_valid;
         if (in_valid) begin
            r_row_a <= w_sum_row;
            r_row_b <= w_carry_row;
            r_mode1 <= mode;
         end
      end
   end

   // Stage 2 holds prod and out_mode bit-stable while the downstream stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_v2       <= 1'b0;
         r_prod     <= '0;
         r_out_mode <= 1'b0;
      end else if (!w_stall) begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_prod     <= w_final;
            r_out_mode <= r_mode1;
         end
      end
   end

   assign out_valid = r_v2;
   assign prod      = r_prod;
   assign out_mode  = r_out_mode;

endmodule

// File: tb/tb_approx_mult_2step_pipe.sv
// Directed bench for approx_mult_2step_pipe: an 8-bit truncating instance and a 16-bit
// instance with no truncated columns.
module tb_approx_mult_2step_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_out_mode;
   logic [7:0]  a_x, a_y;
   logic [16:0] a_prod;
   logic        b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_out_mode;
   logic [15:0] b_x, b_y;
   logic [32:0] b_prod;

   int total = 0;
   int bad   = 0;

   approx_mult_2step_pipe #(.WIDTH(8), .TRUNC_COLS(4)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .x(a_x), .y(a_y), .mode(a_mode), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .prod(a_prod), .out_mode(a_out_mode)
   );

   approx_mult_2step_pipe #(.WIDTH(16), .TRUNC_COLS(0)) u_dut16 (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .x(b_x), .y(b_y), .mode(b_mode), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .prod(b_prod), .out_mode(b_out_mode)
   );

   // Sum of kept partial products, columns below 4 dropped in mode 1.
   function automatic logic [16:0] ref8(input logic [7:0] xv, input logic [7:0] yv, input logic m);
      logic [16:0] acc;
      acc = 17'd0;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++)
            if (xv[j] && yv[i] && (!m || (i + j) >= 4)) acc = acc + (17'd1 << (i + j));
      return acc;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      a_in_valid = 1'b1; a_x = 8'd9; a_y = 8'd9; a_mode = 1'b0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_x = 16'd0; b_y = 16'd0; b_mode = 1'b0; b_out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      a_in_valid = 1'b0;
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", a_out_valid); end
      total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", a_in_ready); end
      total++; if (a_prod !== 17'd0) begin bad++; $display("FAIL reset_prod: got %0d want 0", a_prod); end
      total++; if (a_out_mode !== 1'b0) begin bad++; $display("FAIL reset_out_mode: got %b want 0", a_out_mode); end
      total++; if (b_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid16: got %b want 0", b_out_valid); end
      tick();
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_input_ignored: got %b want 0", a_out_valid); end
   endtask

   task automatic test_exact();
      logic [7:0]  xs [4] = '{8'd255, 8'd0,   8'd13, 8'd128};
      logic [7:0]  ys [4] = '{8'd255, 8'd200, 8'd11, 8'd2};
      logic [16:0] es [4] = '{17'd65025, 17'd0, 17'd143, 17'd256};
      a_out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         a_x = xs[k]; a_y = ys[k]; a_mode = 1'b0; a_in_valid = 1'b1;
         tick();
         a_in_valid = 1'b0;
         total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL exact_latency[%0d]: got %b want 0", k, a_out_valid); end
         tick();
         total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL exact_valid[%0d]: got %b want 1", k, a_out_valid); end
         total++; if (a_prod !== es[k]) begin bad++; $display("FAIL exact_prod[%0d]: got %0d want %0d", k, a_prod, es[k]); end
         total++; if (a_out_mode !== 1'b0) begin bad++; $display("FAIL exact_mode[%0d]: got %b want 0", k, a_out_mode); end
      end
      tick();
   endtask

   task automatic test_trunc();
      // 15*15: columns 0..3 hold 1,2,3,4 ones -> 1+4+12+32 = 49 dropped -> 176
      logic [7:0]  xs [5] = '{8'd15,  8'd255,    8'd8,  8'd16,  8'd240};
      logic [7:0]  ys [5] = '{8'd15,  8'd255,    8'd1,  8'd1,   8'd1};
      logic [16:0] es [5] = '{17'd176, 17'd64976, 17'd0, 17'd16, 17'd240};
      a_out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         a_x = xs[k]; a_y = ys[k]; a_mode = 1'b1; a_in_valid = 1'b1;
         tick();
         a_in_valid = 1'b0;
         tick();
         total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL trunc_valid[%0d]: got %b want 1", k, a_out_valid); end
         total++; if (a_prod !== es[k]) begin bad++; $display("FAIL trunc_prod[%0d]: got %0d want %0d", k, a_prod, es[k]); end
         total++; if (a_out_mode !== 1'b1) begin bad++; $display("FAIL trunc_mode[%0d]: got %b want 1", k, a_out_mode); end
      end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [16:0] exp_q [$];
      logic        expm_q [$];
      logic [16:0] e;
      logic        em;
      int          n_out = 0;
      a_out_ready = 1'b1;
      for (int c = 0; c < 102; c++) begin
         if (c < 100) begin
            a_x = 8'($urandom_range(0, 255)); a_y = 8'($urandom_range(0, 255));
            a_mode = 1'($urandom_range(0, 1)); a_in_valid = 1'b1;
            exp_q.push_back(ref8(a_x, a_y, a_mode));
            expm_q.push_back(a_mode);
         end else begin
            a_in_valid = 1'b0;
         end
         tick();
         total++; if (a_out_valid !== (c >= 1 && c <= 100)) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want %b", c, a_out_valid, (c >= 1 && c <= 100)); end
         if (a_out_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); em = expm_q.pop_front(); n_out++;
            total++; if (a_prod !== e) begin bad++; $display("FAIL b2b_prod[%0d]: got %0d want %0d", c, a_prod, e); end
            total++; if (a_out_mode !== em) begin bad++; $display("FAIL b2b_mode[%0d]: got %b want %b", c, a_out_mode, em); end
         end
      end
      total++; if (n_out != 100) begin bad++; $display("FAIL b2b_count: got %0d want 100", n_out); end
   endtask

   task automatic test_stall();
      // A=200*100 (mode 0), B=77*3 truncated: 231 minus 23 in columns 0..3 = 208, C=5*5
      logic [7:0] xs [3] = '{8'd200, 8'd77, 8'd5};
      logic [7:0] ys [3] = '{8'd100, 8'd3,  8'd5};
      logic       ms [3] = '{1'b0,   1'b1,  1'b0};
      int         idx = 0;
      logic       acc;
      a_out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         a_x = xs[idx]; a_y = ys[idx]; a_mode = ms[idx]; a_in_valid = 1'b1;
         acc = a_in_valid & a_in_ready;
         tick();
         if (acc && idx < 2) idx++;
         else if (acc) idx = 3;
         if (c >= 1) begin
            total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", c, a_in_ready); end
            total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", c, a_out_valid); end
            total++; if (a_prod !== 17'd20000) begin bad++; $display("FAIL stall_hold[%0d]: got %0d want 20000", c, a_prod); end
         end
      end
      total++; if (idx != 2) begin bad++; $display("FAIL stall_accepted: got %0d want 2", idx); end
      a_out_ready = 1'b1;
      a_in_valid  = 1'b0;
      tick();
      total++; if (a_out_valid !== 1'b1) begin bad++; $display("FAIL release_valid: got %b want 1", a_out_valid); end
      total++; if (a_prod !== 17'd208) begin bad++; $display("FAIL release_prod: got %0d want 208", a_prod); end
      total++; if (a_out_mode !== 1'b1) begin bad++; $display("FAIL release_mode: got %b want 1", a_out_mode); end
      tick();
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL release_drain: got %b want 0", a_out_valid); end
   endtask

   task automatic test_reset_midflight();
      a_out_ready = 1'b1;
      a_x = 8'd50; a_y = 8'd50; a_mode = 1'b0; a_in_valid = 1'b1;
      tick();
      a_x = 8'd60; a_y = 8'd60;
      tick();
      a_in_valid = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", a_out_valid); end
      total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b want 1", a_in_ready); end
      total++; if (a_prod !== 17'd0) begin bad++; $display("FAIL midrst_prod: got %0d want 0", a_prod); end
      for (int c = 0; c < 4; c++) begin
         tick();
         total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL midrst_ghost[%0d]: got %b want 0", c, a_out_valid); end
      end
   endtask

   task automatic test_mode_equiv16();
      logic [32:0] exp_q [$];
      logic        expm_q [$];
      logic [32:0] e;
      logic        em;
      int          n_out = 0;
      b_out_ready = 1'b1;
      for (int c = 0; c < 42; c++) begin
         if (c < 40) begin
            if (c % 2 == 0) begin
               b_x = 16'($urandom_range(0, 65535)); b_y = 16'($urandom_range(0, 65535));
            end
            b_mode = 1'(c % 2); b_in_valid = 1'b1;
            exp_q.push_back(33'(b_x) * 33'(b_y));
            expm_q.push_back(b_mode);
         end else begin
            b_in_valid = 1'b0;
         end
         tick();
         if (b_out_valid === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); em = expm_q.pop_front(); n_out++;
            total++; if (b_prod !== e) begin bad++; $display("FAIL w16_prod[%0d]: got %0d want %0d", c, b_prod, e); end
            total++; if (b_out_mode !== em) begin bad++; $display("FAIL w16_mode[%0d]: got %b want %b", c, b_out_mode, em); end
         end
         total++; if (b_prod[32] !== 1'b0) begin bad++; $display("FAIL w16_msb[%0d]: got %b want 0", c, b_prod[32]); end
      end
      total++; if (n_out != 40) begin bad++; $display("FAIL w16_count: got %0d want 40", n_out); end
   endtask

   initial begin
      test_reset();
      test_exact();
      test_trunc();
      test_back_to_back();
      test_stall();
      test_reset_midflight();
      test_mode_equiv16();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
